v8_bka_mul: RTL and testbench

- 8x8 unsigned multiplier built from the Urdhva-Tiryagbhyam (Vedic) decomposition, with Brent-Kung parallel-prefix adders for every partial-product sum.
- Arithmetic core is combinational; the 16-bit product is registered once at the output.
- Used as a leaf arithmetic unit wherever a single-cycle-latency 8-bit unsigned product is needed.

---
 rtl/v8_bka_mul.sv | 128 ++++++++++++
 tb/tb_v8_bka_mul.sv | 109 ++++++++++
 2 files changed

// File: rtl/v8_bka_mul.sv
// ============================================================================
// Module   : v8_bka_mul
// Brief    : 8x8 unsigned Vedic multiplier with Brent-Kung adders, registered q
// Revision : 1.0
// ============================================================================
`default_nettype none

module v8_bka_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_co
);
  localparam int TOP = 2 ** ($clog2(WIDTH) - 1);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_gg;
  logic [WIDTH-1:0] w_gp;

  // In-place prefix tree: the up-sweep leaves full prefixes at 2^k-1, the down-sweep fills the gaps.
  always_comb begin
    w_p  = i_x ^ i_y;
    w_gg = i_x & i_y;
    w_gp = w_p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
        w_gg[i] = w_gg[i] | (w_gp[i] & w_gg[i-d]);
        w_gp[i] = w_gp[i] & w_gp[i-d];
      end
    end
    for (int d = TOP; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
        w_gg[i] = w_gg[i] | (w_gp[i] & w_gg[i-d]);
        w_gp[i] = w_gp[i] & w_gp[i-d];
      end
    end
  end

  assign o_sum = w_p ^ {w_gg[WIDTH-2:0], 1'b0};
  assign o_co  = w_gg[WIDTH-1];
endmodule

module v8_vedic2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);
  logic w_c1;

  assign w_c1   = i_a[1] & i_b[0] & i_a[0] & i_b[1];
  assign o_p[0] = i_a[0] & i_b[0];
  assign o_p[1] = (i_a[1] & i_b[0]) ^ (i_a[0] & i_b[1]);
  assign o_p[2] = (i_a[1] & i_b[1]) ^ w_c1;
  assign o_p[3] = i_a[1] & i_b[1] & w_c1;
endmodule

module v8_vedic4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0] w_ll, w_hl, w_lh, w_hh;
  logic [3:0] w_cross;
  logic       w_cross_co;
  logic [4:0] w_mid;
  logic [3:0] w_upper;
  logic       w_unused_mid_co, w_unused_upper_co;

  v8_vedic2 u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_ll));
  v8_vedic2 u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_hl));
  v8_vedic2 u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_lh));
  v8_vedic2 u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_hh));

  v8_bka_add #(.WIDTH(4)) u_cross (
    .i_x(w_hl), .i_y(w_lh), .o_sum(w_cross), .o_co(w_cross_co));
  v8_bka_add #(.WIDTH(5)) u_mid (
    .i_x({w_cross_co, w_cross}), .i_y({3'b000, w_ll[3:2]}),
    .o_sum(w_mid), .o_co(w_unused_mid_co));
  // Middle sum never exceeds 20, so its bits above 1 fold straight into the hi*hi term.
  v8_bka_add #(.WIDTH(4)) u_upper (
    .i_x({1'b0, w_mid[4:2]}), .i_y(w_hh), .o_sum(w_upper), .o_co(w_unused_upper_co));

  assign o_p = {w_upper, w_mid[1:0], w_ll[1:0]};
endmodule

module v8_bka_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] q
);
  logic [7:0]  w_ll, w_hl, w_lh, w_hh;
  logic [7:0]  w_cross;
  logic        w_cross_co;
  logic [8:0]  w_mid;
  logic [7:0]  w_upper;
  logic        w_unused_mid_co, w_unused_upper_co;
  logic [15:0] w_prod;

  v8_vedic4 u_ll (.i_a(a[3:0]), .i_b(b[3:0]), .o_p(w_ll));
  v8_vedic4 u_hl (.i_a(a[7:4]), .i_b(b[3:0]), .o_p(w_hl));
  v8_vedic4 u_lh (.i_a(a[3:0]), .i_b(b[7:4]), .o_p(w_lh));
  v8_vedic4 u_hh (.i_a(a[7:4]), .i_b(b[7:4]), .o_p(w_hh));

  v8_bka_add #(.WIDTH(8)) u_cross (
    .i_x(w_hl), .i_y(w_lh), .o_sum(w_cross), .o_co(w_cross_co));
  v8_bka_add #(.WIDTH(9)) u_mid (
    .i_x({w_cross_co, w_cross}), .i_y({5'b00000, w_ll[7:4]}),
    .o_sum(w_mid), .o_co(w_unused_mid_co));
  // q[15:4] = mid + (hi*hi << 4); mid[3:0] passes through, so only the top part needs adding.
  v8_bka_add #(.WIDTH(8)) u_upper (
    .i_x({3'b000, w_mid[8:4]}), .i_y(w_hh), .o_sum(w_upper), .o_co(w_unused_upper_co));

  assign w_prod = {w_upper, w_mid[3:0], w_ll[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 16'h0000;
    end else begin
      q <= w_prod;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_v8_bka_mul.sv
// ============================================================================
// Module   : tb_v8_bka_mul
// Brief    : Self-checking bench for v8_bka_mul against an arithmetic model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_v8_bka_mul;
  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] q;

  int n_checks;
  int n_errors;

  v8_bka_mul dut (.clk(clk), .rst(rst), .a(a), .b(b), .q(q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got=%04h expected=%04h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_check(input string tag, input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    step();
    check_eq(tag, q, model(x, y));
  endtask

  logic [7:0]  c_ca [5] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h0F};
  logic [7:0]  c_cb [5] = '{8'h5A, 8'hB7, 8'hFF, 8'h02, 8'hF0};
  logic [15:0] c_cq [5] = '{16'h0000, 16'h00B7, 16'hFE01, 16'h0100, 16'h0E10};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a   = 8'hFF;
    b   = 8'hFF;
    #1;
    check_eq("reset_t0", q, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("reset_hold", q, 16'h0000);
    end
    rst = 1'b0;
    step();
    check_eq("reset_release", q, 16'hFE01);

    for (int i = 0; i < 5; i++) begin
      a = c_ca[i];
      b = c_cb[i];
      step();
      check_eq("corner", q, c_cq[i]);
    end

    a = 8'hAB; b = 8'hCD;
    step();
    check_eq("b2b_first", q, 16'h88EF);
    a = 8'hF0; b = 8'h0F;
    step();
    check_eq("b2b_second", q, 16'h0E10);

    a = 8'h12; b = 8'h34;
    step();
    check_eq("pre_async", q, 16'h03A8);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_drop", q, 16'h0000);
    step();
    check_eq("async_hold", q, 16'h0000);
    rst = 1'b0;
    step();
    check_eq("async_release", q, 16'h03A8);

    for (int i = 0; i < 1000; i++) begin
      apply_check("random", 8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    for (int i = 0; i < 65536; i++) begin
      apply_check("sweep", i[15:8], i[7:0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
